// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage types and constants.
package riscv_pkg;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DISCARD} fetch_state_t;
    localparam int INST_BYTES = 4;
    localparam logic [31:0] NOP_INST = 32'h00000013;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with redirect squash and decode handshake.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);
    fetch_state_t state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    assign target = {redirect_pc[XLEN-1:2], 2'b00};
    assign imem_req_valid = state == REQ;
    assign imem_req_addr = pc;
    assign inst_valid = state == HOLD;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc <= RESET_PC;
            inst_data <= NOP_INST;
            inst_pc <= RESET_PC;
        end else begin
            if (redirect_valid)
                pc <= target;
            case (state)
                IDLE: state <= REQ;
                // an accepted request under redirect still owes a response that must be swallowed
                REQ: if (imem_req_ready) state <= redirect_valid ? DISCARD : WAIT;
                WAIT: begin
                    if (redirect_valid) begin
                        state <= imem_resp_valid ? REQ : DISCARD;
                    end else if (imem_resp_valid) begin
                        inst_data <= imem_resp_data;
                        inst_pc <= pc;
                        state <= HOLD;
                    end
                end
                DISCARD: if (imem_resp_valid) state <= REQ;
                HOLD: begin
                    if (redirect_valid) begin
                        state <= REQ;
                    end else if (inst_ready) begin
                        pc <= pc + XLEN'(INST_BYTES);
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic against a program-order fetch model.
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h00000100;
    logic clk = 0, reset = 0;
    logic imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [31:0] imem_req_addr, imem_resp_data;
    logic inst_valid, inst_ready, redirect_valid;
    logic [31:0] inst_data, inst_pc, redirect_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    int n_checks = 0, n_errors = 0;
    logic [31:0] exp_pc, out_addr, rd_pc, pv_d, pv_p, pv_a;
    logic [31:0] req_log[$];
    int ctimes[$];
    int cyc = 0, deliveries = 0, cnt = 0, lat_max = 1, ir_mode = 1, base;
    bit outst = 0, rdy_rand = 0, junk = 0, rd = 0, pv_iv = 0, pv_rq = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a * 32'h9E3779B1 ^ 32'h00000013;
    endfunction

    function automatic logic [31:0] log_at(int k);
        return req_log.size() > k ? req_log[k] : 32'hxxxxxxxx;
    endfunction

    // one clock of memory, decode and redirect stimulus, with the program-order model alongside
    task automatic step();
        bit acc;
        imem_resp_valid = 0;
        imem_resp_data = $urandom;
        if (outst) begin
            if (cnt == 0) begin
                imem_resp_valid = 1;
                imem_resp_data = mem_word(out_addr);
                outst = 0;
            end else cnt--;
        end else if (junk) imem_resp_valid = ($urandom_range(0, 3) == 0);
        imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        inst_ready = ir_mode == 2 ? 1'($urandom_range(0, 1)) : 1'(ir_mode);
        redirect_valid = rd;
        redirect_pc = rd_pc;
        if (inst_valid) begin
            check("inst_pc", inst_pc, exp_pc);
            check("inst_data", inst_data, mem_word(exp_pc));
        end
        acc = imem_req_valid && imem_req_ready;
        if (acc) begin
            check("single_outstanding", 32'(outst), 0);
            check("req_addr", imem_req_addr, exp_pc);
            req_log.push_back(imem_req_addr);
            outst = 1;
            out_addr = imem_req_addr;
            cnt = $urandom_range(1, lat_max) - 1;
        end
        if (inst_valid && inst_ready && !rd) begin
            deliveries++;
            ctimes.push_back(cyc);
            exp_pc += 32'd4;
        end
        if (rd) exp_pc = rd_pc & ~32'h3;
        pv_iv = inst_valid && !inst_ready && !rd;
        pv_d = inst_data;
        pv_p = inst_pc;
        pv_rq = !acc && imem_req_valid && !rd;
        pv_a = imem_req_addr;
        @(posedge clk);
        #1;
        cyc++;
        rd = 0;
        if (pv_iv) begin
            check("hold_valid", 32'(inst_valid), 1);
            check("hold_data", inst_data, pv_d);
            check("hold_pc", inst_pc, pv_p);
        end
        if (pv_rq) begin
            check("req_hold_valid", 32'(imem_req_valid), 1);
            check("req_hold_addr", imem_req_addr, pv_a);
        end
    endtask

    task automatic check_reset_values();
        check("rst_req_valid", 32'(imem_req_valid), 0);
        check("rst_req_addr", imem_req_addr, RPC);
        check("rst_inst_valid", 32'(inst_valid), 0);
        check("rst_inst_data", inst_data, 32'h00000013);
        check("rst_inst_pc", inst_pc, RPC);
    endtask

    initial begin
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
        inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
        exp_pc = RPC; rd_pc = 0;
        #1 reset = 1;
        #1 check_reset_values();
        repeat (2) @(posedge clk);
        #1 reset = 0;

        for (int i = 0; i < 40 && (req_log.size() < 3 || ctimes.size() < 2); i++) step();
        check("first_req", log_at(0), 32'h100);
        check("second_req", log_at(1), 32'h104);
        check("third_req", log_at(2), 32'h108);
        check("throughput_gap", ctimes.size() >= 2 ? 32'(ctimes[1] - ctimes[0]) : 32'hxxxxxxxx, 3);

        rd = 1; rd_pc = 32'h104;
        for (int i = 0; i < 40 && !(inst_valid && inst_pc == 32'h104); i++) step();
        check("hold_reached", 32'(inst_valid && inst_pc == 32'h104), 1);
        ir_mode = 0;
        repeat (5) begin
            step();
            check("stall_no_req", 32'(imem_req_valid), 0);
            check("stall_valid", 32'(inst_valid), 1);
        end

        ir_mode = 1; rd = 1; rd_pc = 32'h40; req_log.delete();
        step();
        check("squash_valid", 32'(inst_valid), 0);
        for (int i = 0; i < 40 && req_log.size() == 0; i++) step();
        check("squash_next_req", log_at(0), 32'h40);

        for (int i = 0; i < 40 && !(outst && !imem_req_valid && !inst_valid); i++) step();
        check("wait_reached", 32'(outst && !imem_req_valid && !inst_valid), 1);
        rd = 1; rd_pc = 32'h203; req_log.delete();
        step();
        for (int i = 0; i < 40 && req_log.size() == 0; i++) step();
        check("wait_redirect_req", log_at(0), 32'h200);
        for (int i = 0; i < 40 && !inst_valid; i++) step();
        check("wait_redirect_pc", inst_pc, 32'h200);

        rd = 1; rd_pc = 32'hFFFFFFFF; req_log.delete();
        for (int i = 0; i < 40 && req_log.size() < 2; i++) step();
        check("wrap_last", log_at(0), 32'hFFFFFFFC);
        check("wrap_zero", log_at(1), 32'h00000000);

        for (int i = 0; i < 40 && !(outst && !imem_req_valid && !inst_valid); i++) step();
        check("wait_before_reset", 32'(outst && !imem_req_valid && !inst_valid), 1);
        reset = 1;
        #1 check_reset_values();
        outst = 0; exp_pc = RPC; pv_iv = 0; pv_rq = 0; req_log.delete();
        @(posedge clk);
        #1 reset = 0;
        for (int i = 0; i < 40 && req_log.size() == 0; i++) step();
        check("post_reset_req", log_at(0), RPC);

        rdy_rand = 1; lat_max = 4; ir_mode = 2; junk = 1;
        base = deliveries;
        repeat (3000) begin
            if ($urandom_range(0, 9) == 0) begin
                rd = 1;
                rd_pc = $urandom;
            end
            step();
        end
        check("random_progress", 32'(deliveries - base > 100), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
